alu_muldiv_iter: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit. It sits beside the single-cycle ALU in the core's execute stage.
- Takes the 3-bit M-extension funct3 as its opcode.
- Computes in a radix-2 iterative datapath, one bit per cycle.
- Uses a req/ready/valid handshake so the core stalls while the unit is busy.
- Supports flush, so a pending operation can be killed on trap or branch redirect.

---
 rtl/alu_muldiv_iter.sv | 162 ++++++++++++++++
 tb/tb_alu_muldiv_iter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit with req/ready/valid handshake.
// One shift-add (mul) or restoring subtract-shift (div) step per cycle.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_hi, r_lo, r_b;
  logic              r_neg_q, r_neg_r, r_special;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_a_sgn, w_b_sgn, w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res, w_min;
  logic [XLEN:0]     w_sum, w_trial;
  logic [2*XLEN-1:0] w_prod, w_prod_c;
  logic [XLEN-1:0]   w_quot, w_rem, w_result;

  // Accept-time decode: magnitudes and division special cases
  assign w_accept = req_i && (r_state == S_IDLE) && !flush_i;
  assign w_a_sgn  = a_i[XLEN-1] && ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                                    (op_i == OP_DIV)  || (op_i == OP_REM));
  assign w_b_sgn  = b_i[XLEN-1] && ((op_i == OP_MULH) || (op_i == OP_DIV) ||
                                    (op_i == OP_REM));
  assign w_a_mag  = w_a_sgn ? -a_i : a_i;
  assign w_b_mag  = w_b_sgn ? -b_i : b_i;
  assign w_min    = {1'b1, {(XLEN-1){1'b0}}};
  assign w_b_zero = (b_i == '0);
  assign w_ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == w_min) && (b_i == '1);
  assign w_special = op_i[2] && (w_b_zero || w_ovf);

  // op_i[1] distinguishes REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = op_i[1] ? a_i : '1;
    else          w_special_res = op_i[1] ? '0  : a_i;
  end

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_c = r_neg_q ? -w_prod : w_prod;
  assign w_quot   = r_neg_q ? -r_lo : r_lo;
  assign w_rem    = r_neg_r ? -r_hi : r_hi;

  always_comb begin
    w_result = '0;
    if (r_special) begin
      w_result = r_lo;
    end else begin
      case (r_op)
        OP_MUL:                       w_result = w_prod_c[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod_c[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              w_result = w_quot;
        default:                      w_result = w_rem;
      endcase
    end
  end

  // Result is presented combinationally in DONE so a same-cycle flush leaves it untouched
  assign result_o = (r_state == S_DONE && !flush_i) ? w_result : r_result;

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush_i)                     w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_W'(1))     w_state_nxt = S_DONE;
      end
      S_DONE: begin
        valid_o     = !flush_i;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= '0;
    end else if (r_state == S_DONE && !flush_i) begin
      r_result <= w_result;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= CNT_W'(XLEN);
      r_op      <= op_i;
      r_hi      <= '0;
      r_lo      <= w_special ? w_special_res : w_a_mag;
      r_b       <= w_b_mag;
      r_neg_q   <= w_a_sgn ^ w_b_sgn;
      r_neg_r   <= w_a_sgn;
      r_special <= w_special;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_op[2]) begin
        // Restoring division: r_hi is the partial remainder, r_lo shifts dividend out and quotient in
        r_hi <= w_trial[XLEN] ? {r_hi[XLEN-2:0], r_lo[XLEN-1]} : w_trial[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], ~w_trial[XLEN]};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Self-checking bench for alu_muldiv_iter at XLEN=32 and XLEN=8 against a wide-integer model.
module tb_alu_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req32 = 1'b0, flush32 = 1'b0;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ready32, valid32;
  logic [31:0] res32;

  logic        req8 = 1'b0, flush8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, valid8;
  logic [7:0]  res8;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_exp32 = '0;

  always #5 clk = ~clk;

  alu_muldiv_iter #(.XLEN(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req32), .op_i(op32), .a_i(a32), .b_i(b32),
    .flush_i(flush32), .ready_o(ready32), .valid_o(valid32), .result_o(res32)
  );

  alu_muldiv_iter #(.XLEN(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req8), .op_i(op8), .a_i(a8), .b_i(b8),
    .flush_i(flush8), .ready_o(ready8), .valid_o(valid8), .result_o(res8)
  );

  // Reference: plain signed/unsigned arithmetic on wide integers
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int unsigned w);
    logic signed [127:0] ua, ub, sa, sb, p, lim;
    logic [63:0] mask, r;
    mask = (64'd1 << w) - 64'd1;
    ua   = 128'(a & mask);
    ub   = 128'(b & mask);
    lim  = 128'sd1 << w;
    sa   = (ua >= (lim >>> 1)) ? ua - lim : ua;
    sb   = (ub >= (lim >>> 1)) ? ub - lim : ub;
    r    = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[63:0]; end
      3'd1: begin p = sa * sb; p = p >>> w; r = p[63:0]; end
      3'd2: begin p = sa * ub; p = p >>> w; r = p[63:0]; end
      3'd3: begin p = ua * ub; p = p >>> w; r = p[63:0]; end
      3'd4: begin
        if (ub == 0) r = '1;
        else if (sa == -(lim >>> 1) && sb == -1) r = a;
        else begin p = sa / sb; r = p[63:0]; end
      end
      3'd5: begin
        if (ub == 0) r = '1;
        else begin p = ua / ub; r = p[63:0]; end
      end
      3'd6: begin
        if (ub == 0) r = a;
        else if (sa == -(lim >>> 1) && sb == -1) r = '0;
        else begin p = sa % sb; r = p[63:0]; end
      end
      default: begin
        if (ub == 0) r = a;
        else begin p = ua % ub; r = p[63:0]; end
      end
    endcase
    return r & mask;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [63:0] a,
                                     input logic [63:0] b, input int unsigned w);
    logic [63:0] mask, ma, mb;
    logic        ovf;
    mask = (64'd1 << w) - 64'd1;
    ma   = a & mask;
    mb   = b & mask;
    ovf  = (op == 3'd4 || op == 3'd6) && (ma == (64'd1 << (w - 1))) && (mb == mask);
    if (op >= 3'd4 && (mb == 0 || ovf)) return 1;
    return int'(w) + 1;
  endfunction

  task automatic run_op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
    @(negedge clk);
    req32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk);
    @(negedge clk);
    req32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
    lat = 1;
    while (!valid32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = res32;
    if (!valid32) lat = -1;
  endtask

  task automatic run_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [7:0] res);
    @(negedge clk);
    req8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk);
    @(negedge clk);
    req8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!valid8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = res8;
    if (!valid8) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (ready32 !== 1'b1 || valid32 !== 1'b0 || res32 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset32: ready=%b valid=%b result=%h, expected ready=1 valid=0 result=0", ready32, valid32, res32);
    end
    n_checks++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0 || res8 !== 8'h0) begin
      n_errors++;
      $display("FAIL reset8: ready=%b valid=%b result=%h, expected ready=1 valid=0 result=0", ready8, valid8, res8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed32;
    vec_t        v[12];
    int          lat;
    logic [31:0] res;
    v[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    v[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    v[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    v[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    v[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    v[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    v[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    v[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    v[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    v[9]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    v[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    v[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    for (int i = 0; i < 12; i++) begin
      run_op32(v[i].op, v[i].a, v[i].b, lat, res);
      n_checks++;
      if (res !== v[i].exp) begin
        n_errors++;
        $display("FAIL directed32[%0d] result: got %h expected %h", i, res, v[i].exp);
      end
      n_checks++;
      if (lat != v[i].lat) begin
        n_errors++;
        $display("FAIL directed32[%0d] latency: got %0d expected %0d", i, lat, v[i].lat);
      end
      last_exp32 = v[i].exp;
    end
  endtask

  task automatic test_random32;
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat, exp_lat;
    logic [31:0] res;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp     = 32'(ref_model(op, 64'(a), 64'(b), 32));
      exp_lat = ref_latency(op, 64'(a), 64'(b), 32);
      run_op32(op, a, b, lat, res);
      n_checks++;
      if (res !== exp) begin
        n_errors++;
        $display("FAIL random32 op=%0d a=%h b=%h: got %h expected %h", op, a, b, res, exp);
      end
      n_checks++;
      if (lat != exp_lat) begin
        n_errors++;
        $display("FAIL random32 latency op=%0d: got %0d expected %0d", op, lat, exp_lat);
      end
      last_exp32 = exp;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a0, b0, a1, b1, exp0, exp1;
    int          lowcnt, lat;
    bit          seen;
    a0 = $urandom; b0 = 32'($urandom_range(3, 1000));
    a1 = $urandom; b1 = $urandom;
    exp0 = 32'(ref_model(3'd5, 64'(a0), 64'(b0), 32));
    exp1 = 32'(ref_model(3'd0, 64'(a1), 64'(b1), 32));
    @(negedge clk);
    req32 = 1'b1; op32 = 3'd5; a32 = a0; b32 = b0;
    n_checks++;
    if (ready32 !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b ready before accept: got %b expected 1", ready32);
    end
    @(posedge clk);
    lowcnt = 0;
    seen   = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (ready32 === 1'b0) lowcnt++;
      if (valid32 === 1'b1) begin
        seen = 1;
        n_checks++;
        if (res32 !== exp0) begin
          n_errors++;
          $display("FAIL b2b first result: got %h expected %h", res32, exp0);
        end
      end else begin
        op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
      end
    end
    n_checks++;
    if (!seen || lowcnt != 33) begin
      n_errors++;
      $display("FAIL b2b ready-low cycles: got %0d (valid seen %0d) expected 33 (1)", lowcnt, seen);
    end
    op32 = 3'd0; a32 = a1; b32 = b1;
    @(negedge clk);
    n_checks++;
    if (ready32 !== 1'b1 || valid32 !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b after pulse: ready=%b valid=%b expected ready=1 valid=0", ready32, valid32);
    end
    @(posedge clk);
    @(negedge clk);
    req32 = 1'b0;
    n_checks++;
    if (ready32 !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b second accept: ready=%b expected 0", ready32);
    end
    lat = 1;
    while (!valid32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (valid32 !== 1'b1 || lat != 33 || res32 !== exp1) begin
      n_errors++;
      $display("FAIL b2b second op: result %h latency %0d expected %h latency 33", res32, lat, exp1);
    end
    last_exp32 = exp1;
  endtask

  task automatic test_flush;
    int pulses, lat;
    @(negedge clk);
    req32 = 1'b1; op32 = 3'd5; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req32 = 1'b0;
    end
    flush32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush32 = 1'b0;
    n_checks++;
    if (ready32 !== 1'b1 || valid32 !== 1'b0 || res32 !== last_exp32) begin
      n_errors++;
      $display("FAIL flush calc: ready=%b valid=%b result=%h expected 1 0 %h", ready32, valid32, res32, last_exp32);
    end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid32 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || res32 !== last_exp32) begin
      n_errors++;
      $display("FAIL flush no pulse: pulses=%0d result=%h expected 0 %h", pulses, res32, last_exp32);
    end
    // flush in idle beats a simultaneous request
    @(negedge clk);
    req32 = 1'b1; flush32 = 1'b1; op32 = 3'd4; a32 = 32'd9; b32 = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req32 = 1'b0; flush32 = 1'b0;
    n_checks++;
    if (ready32 !== 1'b1 || valid32 !== 1'b0) begin
      n_errors++;
      $display("FAIL flush idle: ready=%b valid=%b expected ready=1 valid=0", ready32, valid32);
    end
    // flush during DONE suppresses the pulse and keeps the old result
    @(negedge clk);
    req32 = 1'b1; op32 = 3'd3; a32 = 32'hFFFFFFFF; b32 = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req32 = 1'b0;
    lat = 1;
    while (lat < 33) begin
      @(negedge clk);
      lat++;
    end
    flush32 = 1'b1;
    #1;
    n_checks++;
    if (valid32 !== 1'b0 || res32 !== last_exp32) begin
      n_errors++;
      $display("FAIL flush done: valid=%b result=%h expected valid=0 result=%h", valid32, res32, last_exp32);
    end
    @(negedge clk);
    flush32 = 1'b0;
    n_checks++;
    if (ready32 !== 1'b1 || res32 !== last_exp32) begin
      n_errors++;
      $display("FAIL flush done after: ready=%b result=%h expected 1 %h", ready32, res32, last_exp32);
    end
  endtask

  task automatic test_reset_midcalc;
    @(negedge clk);
    req32 = 1'b1; op32 = 3'd0; a32 = 32'd123; b32 = 32'd456;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req32 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready32 !== 1'b1 || valid32 !== 1'b0 || res32 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset midcalc: ready=%b valid=%b result=%h expected 1 0 0", ready32, valid32, res32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_exp32 = '0;
    pulses_after_reset();
  endtask

  task automatic pulses_after_reset;
    int pulses;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid32 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL reset midcalc no pulse: pulses=%0d expected 0", pulses);
    end
  endtask

  task automatic test_xlen8;
    int         lat, exp_lat;
    logic [7:0] res, a, b, exp;
    logic [2:0] op;
    run_op8(3'd0, 8'h0F, 8'h11, lat, res);
    n_checks++;
    if (res !== 8'hFF || lat != 9) begin
      n_errors++;
      $display("FAIL x8 mul: got %h lat %0d expected ff lat 9", res, lat);
    end
    run_op8(3'd5, 8'hFF, 8'h10, lat, res);
    n_checks++;
    if (res !== 8'h0F || lat != 9) begin
      n_errors++;
      $display("FAIL x8 divu: got %h lat %0d expected 0f lat 9", res, lat);
    end
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 8'hFF : (($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
      exp     = 8'(ref_model(op, 64'(a), 64'(b), 8));
      exp_lat = ref_latency(op, 64'(a), 64'(b), 8);
      run_op8(op, a, b, lat, res);
      n_checks++;
      if (res !== exp || lat != exp_lat) begin
        n_errors++;
        $display("FAIL x8 random op=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d", op, a, b, res, lat, exp, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed32();
    test_random32();
    test_back_to_back();
    test_flush();
    test_reset_midcalc();
    test_xlen8();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
